// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter/sequencer sharing one UART TX among
// NUM_REQ byte requesters. Issues one data_valid per grant, follows tx_busy
// through the frame, then inserts GAP_CYCLES idle clocks before re-arbitrating.
// Optional build macro: UART_ARB_PRIO_EN gives requester 0 strict priority.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | arbitrating; grants when TX is idle and someone requests
// ISSUE     | tx_data_valid high for this single cycle
// WAIT_BUSY | waiting for TX to raise tx_busy; times out after BUSY_TIMEOUT
// WAIT_DONE | frame in flight; waiting for tx_busy to fall
// GAP       | inter-frame idle gap of GAP_CYCLES clocks
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            cfg_par_en,
    input  logic [NUM_REQ-1:0]            cfg_par_typ,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_busy,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_par_en,
    output logic                          tx_par_typ,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_busy,
    output logic                          err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam int TW = $clog2(BUSY_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_LAST = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic                  tx_data_valid_q, tx_data_valid_d;
    logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;
    logic                  tx_par_en_q, tx_par_en_d;
    logic                  tx_par_typ_q, tx_par_typ_d;
    logic [IW-1:0]         grant_id_q, grant_id_d;
    logic                  err_timeout_q, err_timeout_d;

    logic [NUM_REQ-1:0]    rr_mask;
    logic                  sel_found;
    logic                  sel_keep_ptr;
    logic [IW-1:0]         sel_idx;
    logic                  grant;

    // Pick the first requester at or after the pointer (wrapping); with the
    // priority build, requester 0 overrides and is excluded from the rotation.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        idx          = 0;
        cand         = '0;
        rr_mask      = req_valid;
        sel_found    = 1'b0;
        sel_keep_ptr = 1'b0;
        sel_idx      = '0;
`ifdef UART_ARB_PRIO_EN
        rr_mask[0] = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IW'(idx);
            if (!sel_found && rr_mask[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`ifdef UART_ARB_PRIO_EN
        if (req_valid[0]) begin
            sel_found    = 1'b1;
            sel_idx      = '0;
            sel_keep_ptr = 1'b1;
        end
`endif
    end

    // Grant strobe: only from IDLE and only while the TX reports idle.
    always_comb begin
        grant     = (state_q == S_IDLE) && !tx_busy && sel_found;
        req_ready = '0;
        if (grant) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        gap_cnt_d       = gap_cnt_q;
        to_cnt_d        = to_cnt_q;
        tx_data_valid_d = 1'b0;
        tx_p_data_d     = tx_p_data_q;
        tx_par_en_d     = tx_par_en_q;
        tx_par_typ_d    = tx_par_typ_q;
        grant_id_d      = grant_id_q;
        err_timeout_d   = err_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    tx_data_valid_d = 1'b1;
                    tx_p_data_d     = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    tx_par_en_d     = cfg_par_en[sel_idx];
                    tx_par_typ_d    = cfg_par_typ[sel_idx];
                    grant_id_d      = sel_idx;
                    if (!sel_keep_ptr) begin
                        ptr_d = (sel_idx == PTR_LAST) ? '0 : sel_idx + IW'(1);
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_d      = '0;
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            gap_cnt_q       <= '0;
            to_cnt_q        <= '0;
            tx_data_valid_q <= 1'b0;
            tx_p_data_q     <= '0;
            tx_par_en_q     <= 1'b0;
            tx_par_typ_q    <= 1'b0;
            grant_id_q      <= '0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            gap_cnt_q       <= gap_cnt_d;
            to_cnt_q        <= to_cnt_d;
            tx_data_valid_q <= tx_data_valid_d;
            tx_p_data_q     <= tx_p_data_d;
            tx_par_en_q     <= tx_par_en_d;
            tx_par_typ_q    <= tx_par_typ_d;
            grant_id_q      <= grant_id_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign tx_data_valid = tx_data_valid_q;
    assign tx_p_data     = tx_p_data_q;
    assign tx_par_en     = tx_par_en_q;
    assign tx_par_typ    = tx_par_typ_q;
    assign grant_id      = grant_id_q;
    assign err_timeout   = err_timeout_q;
    assign arb_busy      = (state_q != S_IDLE);

endmodule
